// File: rtl/prog_loader.sv
// Host command responder: loads instruction memory, gates the CPU reset line
// and streams data-memory words back to the host, MSB first.
module prog_loader #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        imem_we,
  output logic [7:0]  imem_addr,
  output logic [31:0] imem_wdata,
  output logic [7:0]  dmem_addr,
  input  logic [31:0] dmem_rdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        err
);

  // state | meaning
  // IDLE  | waiting for a command byte
  // LEN   | waiting for the word count of a load
  // DATA  | assembling a word from four big-endian bytes
  // WRITE | one-cycle instruction memory write strobe
  // ADDR  | waiting for the data-memory word address
  // FETCH | capturing the addressed data word
  // SEND  | streaming the captured word to the host
  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_ADDR, S_FETCH, S_SEND
  } state_t;

  localparam logic [8:0] ILIM = 9'(INSTR_MEM_SIZE);
  localparam logic [8:0] DLIM = 9'(DATA_MEM_SIZE);

  state_t      state_q, state_d;
  logic        rx_ready_d, busy_d, cpu_reset_d, err_d;
  logic        imem_we_d, tx_valid_d;
  logic [7:0]  imem_addr_d, dmem_addr_d, tx_data_d;
  logic [31:0] imem_wdata_d;
  logic [7:0]  len_q, len_d, idx_q, idx_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [31:0] shreg_q, shreg_d;
  logic        rx_fire, tx_fire;
  logic [31:0] word_in, fetch_word;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      rx_ready   <= 1'b1;
      busy       <= 1'b0;
      cpu_reset  <= 1'b0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      dmem_addr  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      bcnt_q     <= '0;
      shreg_q    <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready   <= rx_ready_d;
      busy       <= busy_d;
      cpu_reset  <= cpu_reset_d;
      err        <= err_d;
      imem_we    <= imem_we_d;
      imem_addr  <= imem_addr_d;
      imem_wdata <= imem_wdata_d;
      dmem_addr  <= dmem_addr_d;
      tx_valid   <= tx_valid_d;
      tx_data    <= tx_data_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
    end
  end

  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign word_in    = {shreg_q[23:0], rx_data};
  assign fetch_word = ({1'b0, dmem_addr} >= DLIM) ? 32'h0 : dmem_rdata;

  always_comb begin
    state_d      = state_q;
    cpu_reset_d  = cpu_reset;
    err_d        = err;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    dmem_addr_d  = dmem_addr;
    tx_valid_d   = tx_valid;
    tx_data_d    = tx_data;
    len_d        = len_q;
    idx_d        = idx_q;
    bcnt_d       = bcnt_q;
    shreg_d      = shreg_q;
    case (state_q)
      S_IDLE: if (rx_fire) begin
        case (rx_data)
          8'h01: begin cpu_reset_d = 1'b0; state_d = S_LEN; end
          8'h02: cpu_reset_d = 1'b1;
          8'h03: cpu_reset_d = 1'b0;
          8'h04: state_d = S_ADDR;
          default: err_d = 1'b1;
        endcase
      end
      S_LEN: if (rx_fire) begin
        len_d  = rx_data;
        idx_d  = '0;
        bcnt_d = '0;
        state_d = (rx_data == 8'd0) ? S_IDLE : S_DATA;
      end
      // Write strobe is prepared here so it is registered during WRITE.
      S_DATA: if (rx_fire) begin
        shreg_d = word_in;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          imem_addr_d  = idx_q;
          imem_wdata_d = word_in;
          if ({1'b0, idx_q} >= ILIM) err_d = 1'b1;
          else imem_we_d = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        idx_d   = idx_q + 8'd1;
        state_d = ((idx_q + 8'd1) == len_q) ? S_IDLE : S_DATA;
      end
      S_ADDR: if (rx_fire) begin
        dmem_addr_d = rx_data;
        state_d     = S_FETCH;
      end
      S_FETCH: begin
        if ({1'b0, dmem_addr} >= DLIM) err_d = 1'b1;
        tx_data_d  = fetch_word[31:24];
        shreg_d    = {fetch_word[23:0], 8'h00};
        tx_valid_d = 1'b1;
        bcnt_d     = '0;
        state_d    = S_SEND;
      end
      S_SEND: if (tx_fire) begin
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          tx_data_d = shreg_q[31:24];
          shreg_d   = {shreg_q[23:0], 8'h00};
        end
      end
      default: state_d = S_IDLE;
    endcase
    rx_ready_d = (state_d == S_IDLE) || (state_d == S_LEN) ||
                 (state_d == S_DATA) || (state_d == S_ADDR);
    busy_d     = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: command table plus load/read/reset sequences.
module tb_prog_loader;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [7:0]  dmem_addr;
  logic [31:0] dmem_rdata;
  logic        cpu_reset;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [31:0] dmem [32];
  int          wr_cnt = 0;
  logic [7:0]  wa [16];
  logic [31:0] wd [16];

  prog_loader #(.INSTR_MEM_SIZE(32), .DATA_MEM_SIZE(32)) dut (
    .clock(clock), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .cpu_reset(cpu_reset), .busy(busy), .err(err)
  );

  always #5 clock = ~clock;

  // Out-of-range reads return junk so a missing zero-substitution shows up.
  assign dmem_rdata = (dmem_addr < 8'd32) ? dmem[dmem_addr[4:0]] : 32'hDEADBEEF;

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 16) begin
        wa[wr_cnt] = imem_addr;
        wd[wr_cnt] = imem_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (waited >= 50) check("rx_ready_timeout", 32'(waited), 32'd0);
    @(posedge clock);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clock);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("busy_timeout", 32'(n), 32'd0);
  endtask

  task automatic recv4(input bit toggle, output logic [31:0] word,
                       output int gaps, output int unstable, output int got);
    logic [7:0] held = 8'h00;
    bit holding = 1'b0;
    bit rdy = 1'b1;
    word = 0; gaps = 0; unstable = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      @(negedge clock);
      if (holding && tx_data !== held) unstable++;
      holding  = 1'b0;
      tx_ready = toggle ? rdy : 1'b1;
      rdy      = !rdy;
      if (tx_valid === 1'b1) begin
        if (tx_ready) begin
          word = {word[23:0], tx_data};
          got++;
        end else begin
          held    = tx_data;
          holding = 1'b1;
        end
      end else if (got > 0) begin
        gaps++;
      end
    end
    @(negedge clock);
    tx_ready = 1'b1;
  endtask

  typedef struct {
    logic [7:0] b;
    logic       exp_cpu;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [31:0] word;
    int gaps, unstable, got, w0;

    tbl[0] = '{8'h02, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h02, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h03, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h02, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h03, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h04, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 32; i++) dmem[i] = 32'h1000_0000 + 32'(i);
    dmem[16] = 32'h0000_000C;

    reset = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_rx_ready", {31'b0, rx_ready}, 32'd1);
    check("rst_imem_we", {31'b0, imem_we}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Load two words.
    w0 = wr_cnt;
    send_byte(8'h01);
    @(negedge clock);
    check("load_busy", {31'b0, busy}, 32'd1);
    check("load_cpu_held", {31'b0, cpu_reset}, 32'd0);
    send_byte(8'h02);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    send_byte(8'h9A); send_byte(8'hBC); send_byte(8'hDE); send_byte(8'hF0);
    wait_idle();
    check("load_writes", 32'(wr_cnt - w0), 32'd2);
    check("load_addr0", {24'b0, wa[w0]}, 32'd0);
    check("load_data0", wd[w0], 32'h12345678);
    check("load_addr1", {24'b0, wa[w0+1]}, 32'd1);
    check("load_data1", wd[w0+1], 32'h9ABCDEF0);
    check("load_cpu_after", {31'b0, cpu_reset}, 32'd0);
    check("load_err", {31'b0, err}, 32'd0);

    // Single-byte IDLE commands.
    for (int i = 0; i < 6; i++) begin
      send_byte(tbl[i].b);
      @(negedge clock);
      check($sformatf("cmd%0d_cpu", i), {31'b0, cpu_reset}, {31'b0, tbl[i].exp_cpu});
      check($sformatf("cmd%0d_err", i), {31'b0, err}, {31'b0, tbl[i].exp_err});
      check($sformatf("cmd%0d_busy", i), {31'b0, busy}, {31'b0, tbl[i].exp_busy});
    end

    // READ already issued by the last table entry; address 16, ready held high.
    send_byte(8'h10);
    recv4(1'b0, word, gaps, unstable, got);
    check("rd16_bytes", 32'(got), 32'd4);
    check("rd16_word", word, 32'h0000000C);
    check("rd16_gaps", 32'(gaps), 32'd0);
    check("rd16_done_valid", {31'b0, tx_valid}, 32'd0);
    check("rd16_busy", {31'b0, busy}, 32'd0);
    check("rd16_err", {31'b0, err}, 32'd0);

    // Same read with a stalling host.
    send_byte(8'h04);
    send_byte(8'h10);
    recv4(1'b1, word, gaps, unstable, got);
    check("rd16s_bytes", 32'(got), 32'd4);
    check("rd16s_word", word, 32'h0000000C);
    check("rd16s_stable", 32'(unstable), 32'd0);
    check("rd16s_gaps", 32'(gaps), 32'd0);

    // Another in-range word to exercise all byte lanes.
    send_byte(8'h04);
    send_byte(8'h1F);
    recv4(1'b1, word, gaps, unstable, got);
    check("rd31_word", word, 32'h1000001F);

    // Out-of-range read returns zeros and raises err.
    send_byte(8'h04);
    send_byte(8'h40);
    recv4(1'b0, word, gaps, unstable, got);
    check("rd64_bytes", 32'(got), 32'd4);
    check("rd64_word", word, 32'h00000000);
    check("rd64_err", {31'b0, err}, 32'd1);
    send_byte(8'h07);
    @(negedge clock);
    check("bad_cmd_err", {31'b0, err}, 32'd1);
    check("bad_cmd_busy", {31'b0, busy}, 32'd0);

    // Reset in the middle of a word aborts without writing.
    w0 = wr_cnt;
    send_byte(8'h01); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
    @(negedge clock);
    reset = 1'b0;
    #2;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_err_clr", {31'b0, err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    send_byte(8'h01); send_byte(8'h00);
    wait_idle();
    repeat (3) @(negedge clock);
    check("abort_writes", 32'(wr_cnt - w0), 32'd0);
    check("abort_busy_end", {31'b0, busy}, 32'd0);
    check("abort_cpu", {31'b0, cpu_reset}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
